regfile_mp: RTL and testbench

Parametrised multi-port register file for the copperv core: one write port, `NUM_READ` registered read ports, and an optional hardwired zero entry. Storage is cleared by a one-entry-per-cycle sweep FSM after reset or on request, so it maps onto inferred RAM with no reset fan-out. It sits between decode/writeback and the ALU operand path.

---
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with one write port, NUM_READ
// registered read ports and an optional hardwired zero entry at index 0.
// Storage carries no reset; a sweep FSM writes zero to one entry per cycle
// after reset or on a clear request, so the array can map onto inferred RAM.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clear      synchronous request to (re)start the clear sweep
//   init_busy  high while the sweep runs
//   rd_en/rd/rd_din    write port (enable, index, data)
//   rs_en      per-port read enable
//   rs_addr    packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rs_dout    packed read data,    port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   rs_valid   per-port one-cycle pulse when rs_dout updates
//
// Build option: define REGFILE_BYPASS_EN for write-first forwarding on a
// same-cycle write/read collision; otherwise the read returns the old value.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  output logic                           init_busy,
  input  logic                           rd_en,
  input  logic [ADDR_WIDTH-1:0]          rd,
  input  logic [DATA_WIDTH-1:0]          rd_din,
  input  logic [NUM_READ-1:0]            rs_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rs_dout,
  output logic [NUM_READ-1:0]            rs_valid
);

  localparam logic [0:0] S_INIT  = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_ready;
  logic w_sweep_last;
  logic w_wr_en;

  assign w_ready      = (r_state == S_READY);
  assign w_sweep_last = (r_ptr == ADDR_WIDTH'(DEPTH - 1));
  assign init_busy    = ~w_ready;

  // clear also suppresses a coincident write; index 0 is never stored when hardwired.
  assign w_wr_en = w_ready && rd_en && !clear && !((ZERO_REG != 0) && (rd == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else if (clear) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else if (r_state == S_INIT) begin
      r_ptr <= r_ptr + 1'b1;
      if (w_sweep_last) begin
        r_state <= S_READY;
      end
    end
  end

  // Unreset storage: the sweep owns the write port while not ready.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_en) begin
      r_mem[rd] <= rd_din;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;

    assign w_addr = rs_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (rd == w_addr)) begin
        w_data = rd_din;
      end
`endif
      // Applied last so the zero entry overrides any forwarded data.
      if ((ZERO_REG != 0) && (w_addr == '0)) begin
        w_data = '0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dout  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= w_ready && rs_en[p];
        if (w_ready && rs_en[p]) begin
          r_dout <= w_data;
        end
      end
    end

    assign rs_dout[p*DATA_WIDTH +: DATA_WIDTH] = r_dout;
    assign rs_valid[p]                         = r_valid;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] rd_din = '0;
  logic [1:0]  rs_en = '0;
  logic [9:0]  rs_addr = '0;
  logic [63:0] dout0, dout1;
  logic [1:0]  val0, val1;
  logic        busy0, busy1;

  // dut0 hardwires entry 0, dut1 stores it; both see identical stimulus.
  regfile_mp #(.DATA_WIDTH(32), .DEPTH(DEPTH), .NUM_READ(2), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .init_busy(busy0),
    .rd_en(rd_en), .rd(rd), .rd_din(rd_din),
    .rs_en(rs_en), .rs_addr(rs_addr), .rs_dout(dout0), .rs_valid(val0));

  regfile_mp #(.DATA_WIDTH(32), .DEPTH(DEPTH), .NUM_READ(2), .ZERO_REG(0)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .init_busy(busy1),
    .rd_en(rd_en), .rd(rd), .rd_din(rd_din),
    .rs_en(rs_en), .rs_addr(rs_addr), .rs_dout(dout1), .rs_valid(val1));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: cycles of sweep remaining, plain array of contents.
  int          left;
  logic [31:0] mem [DEPTH];
  logic [31:0] e0 [2];
  logic [31:0] e1 [2];
  logic [1:0]  e_valid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    left = DEPTH;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      e0[p] = '0;
      e1[p] = '0;
    end
    e_valid = '0;
  endtask

  task automatic model_step();
    logic       ready, wr;
    logic [4:0] a;
    if (!rst) begin
      model_reset();
      return;
    end
    ready = (left == 0);
    wr = ready && rd_en && !clear;
    e_valid = '0;
    for (int p = 0; p < 2; p++) begin
      a = rs_addr[p*5 +: 5];
      if (ready && rs_en[p]) begin
        e_valid[p] = 1'b1;
        e1[p] = (BYP && wr && a == rd) ? rd_din : mem[a];
        e0[p] = (a == 0) ? 32'h0 : e1[p];
      end
    end
    if (wr) mem[rd] = rd_din;
    if (clear) begin
      left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end else if (left > 0) begin
      left--;
    end
  endtask

  task automatic compare();
    chk("busy0", busy0, left > 0);
    chk("busy1", busy1, left > 0);
    chk("valid0", val0, e_valid);
    chk("valid1", val1, e_valid);
    chk("dout0", dout0, {e0[1], e0[0]});
    chk("dout1", dout1, {e1[1], e1[0]});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    clear = 1'b0; rd_en = 1'b0; rs_en = '0;
  endtask

  task automatic count_sweep(input string nm);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      tick();
      n++;
    end
    chk(nm, n, 32);
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < DEPTH / 2; i++) begin
      rs_en = 2'b11;
      rs_addr = {5'(2 * i + 1), 5'(2 * i)};
      tick();
      chk(nm, dout1, 64'h0);
    end
    rs_en = '0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        ck;
    logic [31:0] x0;
    logic [31:0] x1;
  } vec_t;

  vec_t tv [11];

  initial begin
    logic [31:0] coll7, coll31;
    int n;
    coll7  = BYP ? 32'h2 : 32'h1;
    coll31 = BYP ? 32'hA5A5A5A5 : 32'h0;
    tv[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  1'b0, 32'h0, 32'h0};
    tv[1]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[2]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd9,  5'd9,  1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    tv[3]  = '{1'b1, 5'd0,  32'h12345678, 2'b00, 5'd0,  5'd0,  1'b0, 32'h0, 32'h0};
    tv[4]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd5,  1'b1, 32'h0, 32'hDEADBEEF};
    tv[5]  = '{1'b1, 5'd7,  32'h1,        2'b00, 5'd0,  5'd0,  1'b0, 32'h0, 32'h0};
    tv[6]  = '{1'b1, 5'd7,  32'h2,        2'b11, 5'd7,  5'd5,  1'b1, coll7, 32'hDEADBEEF};
    tv[7]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd7,  5'd7,  1'b1, 32'h2, 32'h2};
    tv[8]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd1,  1'b1, 32'h0, 32'h0};
    tv[9]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 2'b11, 5'd0,  5'd31, 1'b1, 32'h0, coll31};
    tv[10] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd31, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};

    // Reset held for 3 cycles, then the sweep.
    model_reset();
    #1;
    chk("rst_dout", dout0, 64'h0);
    chk("rst_valid", val0, 2'b00);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    count_sweep("sweep_len");
    read_all_zero("sweep_zero");

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      rd_en = tv[i].we; rd = tv[i].wa; rd_din = tv[i].wd;
      rs_en = tv[i].re; rs_addr = {tv[i].a1, tv[i].a0};
      tick();
      if (tv[i].ck) begin
        chk($sformatf("vec%0d_p0", i), dout0[31:0], tv[i].x0);
        chk($sformatf("vec%0d_p1", i), dout0[63:32], tv[i].x1);
        if (tv[i].re != 2'b00) chk($sformatf("vec%0d_v", i), val0, tv[i].re);
      end
      if (i == 4) chk("nozero_x0", dout1[31:0], 32'h12345678);
    end
    idle_inputs();

    // Randomised traffic, addresses biased low so collisions happen.
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(63) == 0);
      rd_en = $urandom_range(1);
      rd = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(3));
      rd_din = $urandom;
      rs_en = 2'($urandom);
      rs_addr = {5'($urandom_range(3)), ($urandom_range(1) == 1) ? 5'($urandom) : rd};
      tick();
    end
    idle_inputs();
    n = 0;
    while (busy0 && n < 100) begin
      tick();
      n++;
    end
    chk("ready_wait", busy0, 1'b0);

    // Clear restarted mid-sweep.
    for (int i = 1; i <= 3; i++) begin
      rd_en = 1'b1; rd = 5'(i); rd_din = 32'h1000 + 32'(i);
      tick();
    end
    rd_en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1; rd = 5'($urandom_range(1, 3)); rd_din = $urandom;
      rs_en = 2'b11; rs_addr = {5'd2, 5'd1};
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      rd_en = 1'b1; rd = 5'($urandom_range(1, 3)); rd_din = $urandom;
      rs_en = 2'($urandom);
      tick();
      chk("init_novalid", val0, 2'b00);
      n++;
    end
    chk("clear_len", n, 32);
    idle_inputs();
    read_all_zero("clear_zero");

    // Asynchronous reset while a read is pending.
    rd_en = 1'b1; rd = 5'd9; rd_din = 32'hCAFEF00D;
    tick();
    rd_en = 1'b0;
    rs_en = 2'b11; rs_addr = {5'd9, 5'd9};
    tick();
    chk("pre_rst_dout", dout0, {32'hCAFEF00D, 32'hCAFEF00D});
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_dout", dout0, 64'h0);
    chk("arst_valid", val0, 2'b00);
    chk("arst_busy", busy0, 1'b1);
    tick();
    chk("arst_novalid", val0, 2'b00);
    rst = 1'b1;
    rs_en = '0;
    count_sweep("resweep_len");
    rs_en = 2'b11; rs_addr = {5'd9, 5'd9};
    tick();
    chk("resweep_x9", dout1, 64'h0);
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
